cpu_clock_ctrl: RTL

CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

---
 rtl/cpu_clock_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: CPU clock-enable generator for a hobby CPU.
// Produces a registered one-cycle cpu_tick at a selectable rate (free run),
// or one tick per debounced press of the step button (single step). A halt
// request from the CPU freezes ticking until run_sw is released.

module cpu_clock_ctrl #(
   parameter int unsigned CLK_DIV     = 12000,
   parameter int unsigned DEBOUNCE_MS = 8
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic       run_sw,
   input  logic       step_btn,
   input  logic [1:0] speed_sel,
   input  logic       halt_req,
   output logic       cpu_tick,
   output logic       clock_out,
   output logic [1:0] state
);

   localparam int unsigned MS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [MS_W-1:0] MS_LAST = MS_W'(CLK_DIV - 1);

   localparam int unsigned DB_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

   typedef enum logic [1:0] {
      ST_STOP   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   // ------------------------------------------------------------------
   // Millisecond prescaler
   // ------------------------------------------------------------------
   logic [MS_W-1:0] ms_cnt;
   logic            ms_tick;

   assign ms_tick = (ms_cnt == MS_LAST);

   // Count clock_in cycles 0..CLK_DIV-1 and wrap.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         ms_cnt <= '0;
      end else if (ms_tick) begin
         ms_cnt <= '0;
      end else begin
         ms_cnt <= ms_cnt + MS_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Rate counter (speed_sel selects 1/10/100/1000 ms)
   // ------------------------------------------------------------------
   logic [9:0] rate_cnt;
   logic [9:0] rate_last;
   logic [1:0] speed_q;
   logic       speed_chg;
   logic       rate_tick;

   // Decode the terminal count for the selected period.
   always_comb begin
      rate_last = 10'd0;
      unique case (speed_sel)
         2'd0: rate_last = 10'd0;
         2'd1: rate_last = 10'd9;
         2'd2: rate_last = 10'd99;
         2'd3: rate_last = 10'd999;
         default: rate_last = 10'd0;
      endcase
   end

   assign speed_chg = (speed_sel != speed_q);
   assign rate_tick = ms_tick && !speed_chg && (rate_cnt == rate_last);

   // Advance on ms_tick; a speed change restarts the period from zero.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         rate_cnt <= '0;
         speed_q  <= '0;
      end else begin
         speed_q <= speed_sel;
         if (speed_chg) begin
            rate_cnt <= '0;
         end else if (ms_tick) begin
            // >= keeps the counter bounded even if it was ever left above
            // the terminal count.
            if (rate_cnt >= rate_last) begin
               rate_cnt <= '0;
            end else begin
               rate_cnt <= rate_cnt + 10'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Step button: synchronizer, debouncer, press detector
   // ------------------------------------------------------------------
   logic [1:0]      sync_q;
   logic            sync_btn;
   logic            db;
   logic            db_q;
   logic [DB_W-1:0] stab_cnt;
   logic            step_press;

   assign sync_btn = sync_q[1];

   // Two-flop synchronizer for the asynchronous button.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], step_btn};
      end
   end

   // Accept a new level only after DEBOUNCE_MS consecutive disagreeing ms samples.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         db       <= 1'b0;
         stab_cnt <= '0;
      end else if (ms_tick) begin
         if (sync_btn != db) begin
            if (stab_cnt == DB_LAST) begin
               db       <= sync_btn;
               stab_cnt <= '0;
            end else begin
               stab_cnt <= stab_cnt + DB_W'(1);
            end
         end else begin
            stab_cnt <= '0;
         end
      end
   end

   // Delayed copy of db for rising-edge detection.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         db_q <= 1'b0;
      end else begin
         db_q <= db;
      end
   end

   assign step_press = db && !db_q;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   state_t state_q;
   state_t state_d;
   logic   tick_d;

   // Next-state and tick request; halt > stop > rate tick in RUN.
   always_comb begin
      state_d = state_q;
      tick_d  = 1'b0;
      unique case (state_q)
         ST_STOP: begin
            if (run_sw) begin
               state_d = ST_RUN;
            end else if (step_press && !halt_req) begin
               tick_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (halt_req) begin
               state_d = ST_HALTED;
            end else if (!run_sw) begin
               state_d = ST_STOP;
            end else if (rate_tick) begin
               tick_d = 1'b1;
            end
         end
         ST_HALTED: begin
            if (!run_sw) begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase
      // Never allow back-to-back pulses, even with a degenerate prescaler.
      if (cpu_tick) begin
         tick_d = 1'b0;
      end
   end

   // State register plus registered tick and its square-wave companion.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q   <= ST_STOP;
         cpu_tick  <= 1'b0;
         clock_out <= 1'b0;
      end else begin
         state_q  <= state_d;
         cpu_tick <= tick_d;
         if (tick_d) begin
            clock_out <= !clock_out;
         end
      end
   end

   assign state = state_q;

endmodule
